// File: rtl/c_readout_buffer.sv
// ----------------------------------------------------------------------------
// c_readout_buffer
//   Captures one wide result vector from the matrix core into a shadow
//   register and serializes it onto the APB read bus one word per read
//   handshake, most significant word first. The last word carries the
//   leftover low bits, zero-extended. This is the inverse of the A-operand
//   packing, so concatenating the words (full, full, low LAST_W bits)
//   rebuilds the original vector.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst           asynchronous active-high reset
//   i_load_C        core strobe: capture i_C_result this cycle
//   i_C_result      result vector from the matrix core
//   i_read_C_en     APB read of the C window selected
//   i_valid_read    APB read access phase (one word consumed)
//   i_err_clr       clears the sticky error flags
//   o_PRDATA        current read word (combinational, zero when not readable)
//   o_C_ready       buffer holds unread data (registered)
//   o_read_C_done   pulse on the handshake of the last word (combinational)
//   o_ovf_err       sticky: a load was dropped because the buffer was full
//   o_udf_err       sticky: a read handshake hit an empty buffer
// ----------------------------------------------------------------------------
module c_readout_buffer #(
    parameter int DATA_W = 72,
    parameter int WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_C,
    input  logic [DATA_W-1:0] i_C_result,
    input  logic              i_read_C_en,
    input  logic              i_valid_read,
    input  logic              i_err_clr,
    output logic [WORD_W-1:0] o_PRDATA,
    output logic              o_C_ready,
    output logic              o_read_C_done,
    output logic              o_ovf_err,
    output logic              o_udf_err
);

    localparam int NWORDS = (DATA_W + WORD_W - 1) / WORD_W;
    localparam int LAST_W = DATA_W - (NWORDS - 1) * WORD_W;
    localparam int CNT_W  = 2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_shadow;
    logic              r_C_ready;
    logic              r_ovf_err;
    logic              r_udf_err;

    logic [WORD_W-1:0] w_words [NWORDS];
    logic [WORD_W-1:0] w_word_sel;
    logic              w_rd;
    logic              w_full;
    logic              w_last_rd;
    logic              w_capture;
    logic              w_ovf_set;
    logic              w_udf_set;

    // Slice the shadow into bus words: full words from the top, then the
    // zero-extended remainder.
    genvar gk;
    generate
        for (gk = 0; gk < NWORDS - 1; gk++) begin : g_full_words
            assign w_words[gk] = r_shadow[DATA_W-1-gk*WORD_W -: WORD_W];
        end
    endgenerate
    assign w_words[NWORDS-1] = WORD_W'(r_shadow[LAST_W-1:0]);

    // Handshake qualification and the events that drive the state machine.
    always_comb begin
        w_rd      = i_read_C_en & i_valid_read;
        w_full    = (r_state == S_FULL);
        w_last_rd = w_rd & w_full & (r_count == LAST_IDX);
        // A load is accepted when empty, or when the final word leaves this
        // very cycle (the old shadow still feeds PRDATA until the edge).
        w_capture = i_load_C & (~w_full | w_last_rd);
        w_ovf_set = i_load_C & w_full & ~w_last_rd;
        w_udf_set = w_rd & ~w_full;
    end

    // Word mux: one-hot OR over the word slots keyed by the read counter.
    always_comb begin
        w_word_sel = {WORD_W{1'b0}};
        for (int k = 0; k < NWORDS; k++) begin
            w_word_sel = w_word_sel |
                         ((r_count == CNT_W'(k)) ? w_words[k] : {WORD_W{1'b0}});
        end
    end

    // Bus outputs: data only while the window is selected and data is held.
    always_comb begin
        if (i_read_C_en && w_full) begin
            o_PRDATA = w_word_sel;
        end else begin
            o_PRDATA = {WORD_W{1'b0}};
        end
        o_read_C_done = w_last_rd;
    end

    // Readout state machine with sticky error flags; a same-cycle error
    // event overrides err_clr.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_EMPTY;
            r_count   <= {CNT_W{1'b0}};
            r_shadow  <= {DATA_W{1'b0}};
            r_C_ready <= 1'b0;
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            r_ovf_err <= (r_ovf_err & ~i_err_clr) | w_ovf_set;
            r_udf_err <= (r_udf_err & ~i_err_clr) | w_udf_set;
            case (r_state)
                S_EMPTY: begin
                    if (w_capture) begin
                        r_shadow  <= i_C_result;
                        r_count   <= {CNT_W{1'b0}};
                        r_state   <= S_FULL;
                        r_C_ready <= 1'b1;
                    end else begin
                        r_state   <= S_EMPTY;
                        r_C_ready <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (w_capture) begin
                        r_shadow  <= i_C_result;
                        r_count   <= {CNT_W{1'b0}};
                        r_state   <= S_FULL;
                        r_C_ready <= 1'b1;
                    end else if (w_last_rd) begin
                        r_count   <= {CNT_W{1'b0}};
                        r_state   <= S_EMPTY;
                        r_C_ready <= 1'b0;
                    end else if (w_rd) begin
                        r_count   <= r_count + CNT_W'(1);
                        r_state   <= S_FULL;
                        r_C_ready <= 1'b1;
                    end else begin
                        r_state   <= S_FULL;
                        r_C_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_EMPTY;
                    r_count   <= {CNT_W{1'b0}};
                    r_C_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_C_ready = r_C_ready;
    assign o_ovf_err = r_ovf_err;
    assign o_udf_err = r_udf_err;

endmodule
